// File: rtl/sigma_pkg.sv
// Shared types for the sigma memory-port arbiter:
// FSM state encoding, access owner IDs and bus widths.
package sigma_pkg;

    localparam int ADDR_W = 17;
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_START,
        ARB_WAIT,
        ARB_ACK
    } arb_state_e;

    typedef enum logic {
        OWN_CPU,
        OWN_IOP
    } owner_e;

endpackage

// File: rtl/sigma_mem_arbiter.sv
// Shares the core-memory port between CPU and IOP: one access at a time,
// fixed read latency, CPU locked RMW and a bound on IOP starvation of the CPU.
module sigma_mem_arbiter
    import sigma_pkg::*;
#(
    parameter int MEM_LAT       = 2,
    parameter int IOP_BURST_MAX = 4,
    parameter int MEM_WORDS     = 131072
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic              cpu_lock,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [WORD_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic              cpu_err,
    output logic [WORD_W-1:0] cpu_rdata,
    input  logic              iop_req,
    input  logic              iop_wr,
    input  logic [ADDR_W-1:0] iop_addr,
    input  logic [WORD_W-1:0] iop_wdata,
    output logic              iop_ack,
    output logic              iop_err,
    output logic [WORD_W-1:0] iop_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata
);

    localparam logic [3:0]      LAT_INIT  = 4'(MEM_LAT - 1);
    localparam logic [3:0]      BURST     = 4'(IOP_BURST_MAX);
    localparam logic [ADDR_W:0] WORDS_LIM = (ADDR_W+1)'(MEM_WORDS);

    arb_state_e        state_q, state_d;
    owner_e            owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              wr_q, wr_d;
    logic              lk_q, lk_d;
    logic              err_q, err_d;
    logic              lock_q, lock_d;
    logic [3:0]        lat_q, lat_d;
    logic [3:0]        starve_q, starve_d;
    logic [WORD_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [WORD_W-1:0] iop_rdata_q, iop_rdata_d;
    logic              grant_cpu, grant_iop;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ARB_IDLE;
            owner_q     <= OWN_CPU;
            addr_q      <= '0;
            wdata_q     <= '0;
            wr_q        <= 1'b0;
            lk_q        <= 1'b0;
            err_q       <= 1'b0;
            lock_q      <= 1'b0;
            lat_q       <= '0;
            starve_q    <= '0;
            cpu_rdata_q <= '0;
            iop_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wr_q        <= wr_d;
            lk_q        <= lk_d;
            err_q       <= err_d;
            lock_q      <= lock_d;
            lat_q       <= lat_d;
            starve_q    <= starve_d;
            cpu_rdata_q <= cpu_rdata_d;
            iop_rdata_q <= iop_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wr_d        = wr_q;
        lk_d        = lk_q;
        err_d       = err_q;
        lock_d      = lock_q;
        lat_d       = lat_q;
        starve_d    = starve_q;
        cpu_rdata_d = cpu_rdata_q;
        iop_rdata_d = iop_rdata_q;
        grant_cpu   = 1'b0;
        grant_iop   = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                // A held lock shuts the IOP out until the CPU releases it.
                if (lock_q) begin
                    grant_cpu = cpu_req;
                end else if (cpu_req && iop_req) begin
                    grant_cpu = (starve_q == BURST);
                    grant_iop = !grant_cpu;
                end else begin
                    grant_cpu = cpu_req;
                    grant_iop = iop_req;
                end
                if (!cpu_req || grant_cpu) begin
                    starve_d = '0;
                end else if (grant_iop && starve_q != BURST) begin
                    starve_d = starve_q + 4'd1;
                end
                if (!cpu_req && !cpu_lock) begin
                    lock_d = 1'b0;
                end
                if (grant_cpu || grant_iop) begin
                    owner_d = grant_iop ? OWN_IOP : OWN_CPU;
                    addr_d  = grant_iop ? iop_addr : cpu_addr;
                    wdata_d = grant_iop ? iop_wdata : cpu_wdata;
                    wr_d    = grant_iop ? iop_wr : cpu_wr;
                    lk_d    = grant_cpu & cpu_lock;
                    err_d   = ({1'b0, addr_d} >= WORDS_LIM);
                    if (err_d) begin
                        state_d = ARB_ACK;
                        if (grant_iop) iop_rdata_d = '0;
                        else           cpu_rdata_d = '0;
                    end else begin
                        state_d = ARB_START;
                    end
                end
            end
            ARB_START: begin
                lat_d   = LAT_INIT;
                state_d = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (lat_q == 4'd0) begin
                    state_d = ARB_ACK;
                    if (!wr_q) begin
                        if (owner_q == OWN_IOP) iop_rdata_d = mem_rdata;
                        else                    cpu_rdata_d = mem_rdata;
                    end
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
            ARB_ACK: begin
                state_d = ARB_IDLE;
                if (owner_q == OWN_CPU) lock_d = lk_q;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign cpu_ack   = (state_q == ARB_ACK) && (owner_q == OWN_CPU);
    assign iop_ack   = (state_q == ARB_ACK) && (owner_q == OWN_IOP);
    assign cpu_err   = cpu_ack & err_q;
    assign iop_err   = iop_ack & err_q;
    assign cpu_rdata = cpu_rdata_q;
    assign iop_rdata = iop_rdata_q;
    assign mem_en    = (state_q == ARB_START);
    assign mem_we    = mem_en & wr_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_sigma_mem_arbiter.sv
// Bench for sigma_mem_arbiter: directed scenarios plus random CPU/IOP
// traffic checked cycle by cycle against a transaction-level model.
module tb_sigma_mem_arbiter;

    localparam int LAT   = 2;
    localparam int BURST = 4;
    localparam int WORDS = 65536;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_req = 1'b0, cpu_wr = 1'b0, cpu_lock = 1'b0;
    logic [16:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        cpu_ack, cpu_err;
    logic [31:0] cpu_rdata;
    logic        iop_req = 1'b0, iop_wr = 1'b0;
    logic [16:0] iop_addr = '0;
    logic [31:0] iop_wdata = '0;
    logic        iop_ack, iop_err;
    logic [31:0] iop_rdata;
    logic        mem_en, mem_we;
    logic [16:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;

    sigma_mem_arbiter #(
        .MEM_LAT      (LAT),
        .IOP_BURST_MAX(BURST),
        .MEM_WORDS    (WORDS)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .cpu_req  (cpu_req),
        .cpu_wr   (cpu_wr),
        .cpu_lock (cpu_lock),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_ack  (cpu_ack),
        .cpu_err  (cpu_err),
        .cpu_rdata(cpu_rdata),
        .iop_req  (iop_req),
        .iop_wr   (iop_wr),
        .iop_addr (iop_addr),
        .iop_wdata(iop_wdata),
        .iop_ack  (iop_ack),
        .iop_err  (iop_err),
        .iop_rdata(iop_rdata),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // memory contents: env side (served on the DUT port) and model side
    logic [31:0] env_mem[int];
    logic [31:0] model_mem[int];
    int          env_due = -1;
    logic [31:0] env_val = '0;

    function automatic logic [31:0] init_word(logic [16:0] a);
        return 32'h5A5A_0000 ^ {15'h0, a} ^ {a[15:0], 16'h0};
    endfunction

    function automatic logic [31:0] env_rd(logic [16:0] a);
        return env_mem.exists(int'(a)) ? env_mem[int'(a)] : init_word(a);
    endfunction

    function automatic logic [31:0] model_rd(logic [16:0] a);
        return model_mem.exists(int'(a)) ? model_mem[int'(a)] : init_word(a);
    endfunction

    // transaction-level reference model
    int          cyc = 0;
    bit          m_busy = 0, m_iop = 0, m_fault = 0, m_wr = 0, m_lk = 0;
    int          m_start = 0, m_ack = 0, m_idle_from = 0;
    logic [16:0] m_addr = '0;
    logic [31:0] m_wdata = '0, m_rd = '0;
    bit          m_lock = 0;
    int          m_starve = 0;
    logic [31:0] m_cpu_rd = '0, m_iop_rd = '0;
    bit          ack_c = 0, ack_i = 0, seen_c = 0, seen_i = 0;
    int          cnt_c = 0, cnt_i = 0;
    bit          auto_on = 0, cpu_pend = 0, iop_pend = 0;

    task automatic model_reset();
        m_busy      = 0;
        m_lock      = 0;
        m_starve    = 0;
        m_cpu_rd    = '0;
        m_iop_rd    = '0;
        m_idle_from = cyc;
        env_due     = -1;
        ack_c       = 0;
        ack_i       = 0;
    endtask

    task automatic decide();
        bit gc, gi;
        gc = 0;
        gi = 0;
        if (m_busy || cyc < m_idle_from) return;
        if (m_lock) gc = cpu_req;
        else if (cpu_req && iop_req) begin
            gc = (m_starve == BURST);
            gi = !gc;
        end else begin
            gc = cpu_req;
            gi = iop_req;
        end
        if (!cpu_req || gc) m_starve = 0;
        else if (gi && m_starve < BURST) m_starve++;
        if (!cpu_req && !cpu_lock) m_lock = 0;
        if (gc || gi) begin
            m_busy  = 1;
            m_iop   = gi;
            m_addr  = gi ? iop_addr : cpu_addr;
            m_wr    = gi ? iop_wr : cpu_wr;
            m_wdata = gi ? iop_wdata : cpu_wdata;
            m_lk    = gc && cpu_lock;
            m_fault = int'(m_addr) >= WORDS;
            m_start = cyc + 1;
            m_ack   = m_fault ? cyc + 1 : cyc + LAT + 2;
            if (!m_fault) begin
                m_rd = model_rd(m_addr);
                if (m_wr) model_mem[int'(m_addr)] = m_wdata;
            end
        end
    endtask

    task automatic observe();
        bit ea_c, ea_i, een;
        ea_c = m_busy && cyc == m_ack && !m_iop;
        ea_i = m_busy && cyc == m_ack && m_iop;
        een  = m_busy && !m_fault && cyc == m_start;
        if (ea_c) begin
            m_cpu_rd = m_fault ? 32'h0 : (m_wr ? m_cpu_rd : m_rd);
            m_lock   = m_lk;
        end
        if (ea_i) m_iop_rd = m_fault ? 32'h0 : (m_wr ? m_iop_rd : m_rd);
        chk("cpu_ack", 32'(cpu_ack), 32'(ea_c));
        chk("iop_ack", 32'(iop_ack), 32'(ea_i));
        chk("mem_en", 32'(mem_en), 32'(een));
        if (ea_c) chk("cpu_err", 32'(cpu_err), 32'(m_fault));
        if (ea_i) chk("iop_err", 32'(iop_err), 32'(m_fault));
        chk("cpu_rdata", cpu_rdata, m_cpu_rd);
        chk("iop_rdata", iop_rdata, m_iop_rd);
        if (een) begin
            chk("mem_we", 32'(mem_we), 32'(m_wr));
            chk("mem_addr", 32'(mem_addr), 32'(m_addr));
            if (m_wr) chk("mem_wdata", mem_wdata, m_wdata);
        end
        if (mem_en) begin
            env_val = env_rd(mem_addr);
            env_due = cyc + LAT;
            if (mem_we) env_mem[int'(mem_addr)] = mem_wdata;
        end
        ack_c  = ea_c;
        ack_i  = ea_i;
        seen_c = cpu_ack;
        seen_i = iop_ack;
        if (cpu_ack) cnt_c++;
        if (iop_ack) cnt_i++;
        if (ea_c || ea_i) begin
            m_busy      = 0;
            m_idle_from = cyc + 1;
        end
    endtask

    function automatic logic [16:0] rnd_addr();
        int r;
        r = int'($urandom % 10);
        if (r == 0) return 17'(32'd65536 + $urandom % 65536);
        if (r == 1) return 17'h100;
        return 17'($urandom % 16);
    endfunction

    task automatic agents();
        if (ack_c) cpu_pend = 0;
        if (ack_i) iop_pend = 0;
        if (!cpu_pend) begin
            if ($urandom % 100 < 35) begin
                cpu_pend  = 1;
                cpu_req   = 1'b1;
                cpu_addr  = rnd_addr();
                cpu_wr    = 1'($urandom % 2);
                cpu_wdata = $urandom;
                cpu_lock  = ($urandom % 4 == 0);
            end else begin
                cpu_req = 1'b0;
                if ($urandom % 3 == 0) cpu_lock = 1'b0;
            end
        end
        if (!iop_pend) begin
            if ($urandom % 100 < 60) begin
                iop_pend  = 1;
                iop_req   = 1'b1;
                iop_addr  = rnd_addr();
                iop_wr    = 1'($urandom % 2);
                iop_wdata = $urandom;
            end else begin
                iop_req = 1'b0;
            end
        end
    endtask

    task automatic tick();
        if (auto_on) agents();
        mem_rdata = (cyc == env_due) ? env_val : $urandom;
        decide();
        cyc++;
        @(negedge clock);
        observe();
    endtask

    task automatic run_until(input bit iop, output int n);
        bit got;
        got = 0;
        n   = 0;
        for (int k = 0; k < 60 && !got; k++) begin
            tick();
            n++;
            got = iop ? seen_i : seen_c;
        end
        chk("ack_timeout", 32'(got), 32'd1);
    endtask

    task automatic rst_chk(input string p);
        chk({p, "_cpu_ack"}, 32'(cpu_ack), 32'd0);
        chk({p, "_cpu_err"}, 32'(cpu_err), 32'd0);
        chk({p, "_cpu_rdata"}, cpu_rdata, 32'd0);
        chk({p, "_iop_ack"}, 32'(iop_ack), 32'd0);
        chk({p, "_iop_err"}, 32'(iop_err), 32'd0);
        chk({p, "_iop_rdata"}, iop_rdata, 32'd0);
        chk({p, "_mem_en"}, 32'(mem_en), 32'd0);
        chk({p, "_mem_we"}, 32'(mem_we), 32'd0);
        chk({p, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({p, "_mem_wdata"}, mem_wdata, 32'd0);
    endtask

    task automatic cpu_drive(input logic [16:0] a, input bit w,
                             input logic [31:0] d, input bit lk);
        cpu_req   = 1'b1;
        cpu_addr  = a;
        cpu_wr    = w;
        cpu_wdata = d;
        cpu_lock  = lk;
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clock);
        rst_chk("por");
        reset_n = 1'b1;
        model_reset();

        // single CPU read with a known memory word
        env_mem[32'h100]   = 32'hDEADBEEF;
        model_mem[32'h100] = 32'hDEADBEEF;
        cpu_drive(17'h100, 0, '0, 0);
        run_until(0, n);
        chk("rd_latency", 32'(n), 32'd4);
        chk("rd_data", cpu_rdata, 32'hDEADBEEF);
        cpu_req = 1'b0;
        repeat (2) tick();

        // simultaneous requests: IOP first, CPU in the next IDLE
        cpu_drive(17'h3, 0, '0, 0);
        iop_req  = 1'b1;
        iop_wr   = 1'b1;
        iop_addr = 17'h3;
        iop_wdata = 32'h1234_5678;
        run_until(1, n);
        chk("both_iop_first", 32'(n), 32'd4);
        iop_req = 1'b0;
        run_until(0, n);
        chk("both_cpu_next", 32'(n), 32'd5);
        chk("both_cpu_data", cpu_rdata, 32'h1234_5678);
        cpu_req = 1'b0;
        repeat (2) tick();

        // IOP held continuously while the CPU waits
        cpu_drive(17'h4, 0, '0, 0);
        iop_req = 1'b1;
        iop_wr  = 1'b0;
        cnt_i   = 0;
        run_until(0, n);
        chk("burst_iop_acks", 32'(cnt_i), 32'(BURST));
        cpu_req = 1'b0;
        run_until(1, n);
        chk("burst_iop_resume", 32'(n), 32'd5);
        iop_req = 1'b0;
        repeat (2) tick();

        // locked read-modify-write keeps the IOP out
        cpu_drive(17'h200, 0, '0, 1);
        run_until(0, n);
        cpu_req = 1'b0;
        iop_req = 1'b1;
        cnt_i   = 0;
        repeat (3) tick();
        cpu_drive(17'h200, 1, 32'hCAFE_F00D, 0);
        run_until(0, n);
        chk("lock_iop_blocked", 32'(cnt_i), 32'd0);
        cpu_req = 1'b0;
        run_until(1, n);
        chk("lock_iop_after", 32'(n), 32'd5);
        iop_req = 1'b0;
        repeat (2) tick();

        // unimplemented address faults without a memory cycle
        cpu_drive(17'h1FFFF, 0, '0, 0);
        run_until(0, n);
        chk("fault_latency", 32'(n), 32'd1);
        chk("fault_err", 32'(cpu_err), 32'd1);
        chk("fault_rdata", cpu_rdata, 32'd0);
        cpu_req = 1'b0;
        repeat (2) tick();

        // random traffic
        auto_on = 1;
        repeat (3000) tick();
        auto_on  = 0;
        cpu_req  = 1'b0;
        iop_req  = 1'b0;
        cpu_lock = 1'b0;
        cpu_pend = 0;
        iop_pend = 0;
        repeat (20) tick();

        // reset while an access is in WAIT
        cpu_drive(17'h5, 0, '0, 0);
        repeat (2) tick();
        reset_n = 1'b0;
        #1;
        rst_chk("wait_rst");
        model_reset();
        cpu_req = 1'b0;
        tick();
        reset_n = 1'b1;
        cpu_drive(17'h7, 0, '0, 0);
        run_until(0, n);
        chk("post_rst_latency", 32'(n), 32'd4);
        cpu_req = 1'b0;
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
